fnd_scan_capture: RTL and testbench
===================================

# fnd_scan_capture

Passive monitor at the far end of the 4-digit multiplexed 7-segment (FND) bus. It samples the `fnd_com` and `fnd_font` lines that the FND controller drives, and rebuilds the displayed number from them:
- the decoded BCD digit of each position;
- the binary value (0–9999);
- the per-digit decimal-point state.

It feeds self-check logic and the UART report path. It decodes what was physically shown, independent of the data source.

## Interface
- `SETTLE_CYCLES`, default 16: number of clk cycles that `com` and `font` must hold stable before a digit is sampled.
- `TIMEOUT_CYCLES`, default 1_000_000: cycles with no `com` change before the scan is declared stale (10 ms at 100 MHz).
- `clk`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-low reset.
- `fnd_com`, input, 4: digit enables, active-low. Bit 0 is the ones digit, bit 3 the thousands digit.
- `fnd_font`, input, 8: segments, active-low. Bits [6:0] are g..a; bit 7 is dp.
- `digit_1`, `digit_10`, `digit_100`, `digit_1000`, output, 4 each: last complete frame, BCD.
- `value`, output, 14: last complete frame as binary, d1000·1000 + d100·100 + d10·10 + d1.
- `dp`, output, 4: dp lit per position (1 = lit), last frame.
- `blank`, output, 4: position was blank (font[6:0] = 7'h7F) in the last frame.
- `frame_valid`, output, 1: one-cycle pulse when the outputs above update.
- `font_err`, output, 1: sticky. Set when an undecodable pattern is sampled; cleared at the next `frame_valid`.
- `stale`, output, 1: set when no `com` transition has occurred for `TIMEOUT_CYCLES`; cleared at the next `frame_valid`.

## Operation
- **Input synchronisation:** `fnd_com` and `fnd_font` pass through 2-flop synchronisers. All logic below uses the synchronised copies `s_com` and `s_font`.
- **Valid `s_com`:** exactly one bit is 0. All-ones or multiple-zero patterns are ignored.
- **Font decode** (`s_font[6:0]`, active-low):

| Pattern | Decodes to |
|---|---|
| 40 | 0 |
| 79 | 1 |
| 24 | 2 |
| 30 | 3 |
| 19 | 4 |
| 12 | 5 |
| 02 | 6 |
| 78 | 7 |
| 00 | 8 |
| 10 | 9 |
| 7F | blank, digit 0 |
| anything else | invalid |

- **dp:** dp lit = ~`s_font[7]`.
- **FSM states:**
  - **WAIT_COM:**
    - Stay while `s_com` is invalid.
    - On a valid `s_com`: latch `cur_com`, clear `settle_cnt`, go to SETTLE.
  - **SETTLE:**
    - `settle_cnt` increments while `s_com == cur_com` and `s_font` equals its previous-cycle value.
    - A font change clears `settle_cnt`.
    - A `com` change returns to WAIT_COM.
    - When `settle_cnt == SETTLE_CYCLES-1`, go to SAMPLE.
  - **SAMPLE:** one cycle.
    - Write the decoded digit, dp and blank into the slot selected by `cur_com`.
    - Set that bit of `got_mask`.
    - If the pattern is invalid, set `font_err`; the slot is written as 0 and the mask bit is still set.
    - If `got_mask` is now 4'b1111, go to CONVERT; otherwise go to HOLD.
  - **HOLD:** stay until `s_com != cur_com`, then go to WAIT_COM. This gives one sample per digit per scan pass.
  - **CONVERT:** four cycles.
    - Starting from `acc = 0`, compute `acc = acc*10 + slot`, taking slots in order 1000, 100, 10, 1.
    - `acc` is 14 bits; max 9999 does not overflow.
    - Implement ×10 as (acc<<3) + (acc<<1).
  - **PUBLISH:** one cycle.
    - Copy `acc` and the slots to the outputs.
    - Pulse `frame_valid`.
    - Clear `got_mask`, `font_err` and `stale`.
    - Go to HOLD.
- **Slot overwrite:** a slot re-sampled before the frame completes is overwritten; the newest sample wins.
- **Timeout:**
  - `to_cnt` clears on every `s_com` change and otherwise saturates at `TIMEOUT_CYCLES`.
  - On reaching `TIMEOUT_CYCLES`: set `stale`, clear `got_mask`. The FSM continues normally.
- **Reset (asynchronous, any state):**
  - FSM goes to WAIT_COM.
  - All counters, `got_mask`, `acc` and slots are cleared.
  - All outputs go to 0: digits, `value`, `dp`, `blank`, `frame_valid`, `font_err`, `stale`.
  - A conversion in progress is discarded.

## Timing
- **Digit sample:** 2 sync cycles + `SETTLE_CYCLES` + 1 after `com`/`font` become stable at the pins.
- **Frame output:** `frame_valid` occurs 5 cycles after the SAMPLE that completes the mask (4 CONVERT + 1 PUBLISH).
- **Output hold:** outputs hold their values between pulses and change only in PUBLISH.
- **Short dwell:** a `com` dwell shorter than 2 + `SETTLE_CYCLES` is never sampled.
- **Simultaneous events:**
  - A timeout coinciding with PUBLISH: PUBLISH wins, `stale` = 0.
  - A `com` change during CONVERT or PUBLISH is ignored until HOLD.

## Test plan
- **Full frame:** drive a scan of 1234 with dp off and 2 µs dwell per digit → `frame_valid` pulses, `value` = 1234, digits 1/2/3/4, `dp` = 0, `font_err` = 0.
- **Boundary values:** scan 9999, then 0000 → `value` = 9999 (14'h270F), then 0. Blank thousands/hundreds (font 7F) with "42" → `value` = 42, `blank` = 4'b1100.
- **Glitch rejection:**
  - Toggle `font` for 3 cycles mid-dwell → `settle_cnt` restarts, the correct digit is still captured.
  - Use a dwell of `SETTLE_CYCLES`-1 cycles → no sample, no `frame_valid`.
- **Invalid font and dp:**
  - Font 7'h55 on the tens digit → `font_err` = 1, `digit_10` = 0 at the pulse.
  - The next clean frame → `font_err` = 0.
  - dp low on the hundreds digit → `dp` = 4'b0100.
- **Timeout:**
  - Hold `com` = 4'b1110 for `TIMEOUT_CYCLES` → `stale` = 1, partial mask discarded (no pulse until 4 fresh digits).
  - Resume scanning → `stale` = 0 at the next pulse.
- **Reset:** assert `reset` low during CONVERT → all outputs 0 immediately, no `frame_valid`; after release, capture resumes from WAIT_COM.

Source files
------------

// File: rtl/fnd_scan_capture.sv
// Passive monitor for a 4-digit multiplexed 7-segment bus: samples each digit once
// it has settled, then rebuilds BCD digits, binary value, dp and blank per frame.
module fnd_scan_capture #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fnd_com,
    input  logic [7:0]  fnd_font,
    output logic [3:0]  digit_1,
    output logic [3:0]  digit_10,
    output logic [3:0]  digit_100,
    output logic [3:0]  digit_1000,
    output logic [13:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        font_err,
    output logic        stale
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_COM, SETTLE, SAMPLE, HOLD, CONVERT, PUBLISH
    } state_t;

    state_t state_q, state_d;

    logic [3:0] com_s1, s_com, com_prev, cur_com;
    logic [7:0] font_s1, s_font, font_prev;

    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   to_cnt;
    logic [1:0]      conv_cnt;
    logic [3:0]      got_mask;
    logic [13:0]     acc;
    logic [3:0][3:0] slot_d;
    logic [3:0]      slot_dp, slot_blank;

    logic       com_ok, com_chg, to_hit;
    logic [3:0] com_inv, slot_bit, mask_after;
    logic [1:0] slot_idx;
    logic [3:0] dec_digit;
    logic       dec_valid, dec_blank;

    // Both buses are asynchronous to clk; the previous-cycle copies feed change detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_s1    <= 4'hF;
            s_com     <= 4'hF;
            com_prev  <= 4'hF;
            font_s1   <= 8'hFF;
            s_font    <= 8'hFF;
            font_prev <= 8'hFF;
        end else begin
            com_s1    <= fnd_com;
            s_com     <= com_s1;
            com_prev  <= s_com;
            font_s1   <= fnd_font;
            s_font    <= font_s1;
            font_prev <= s_font;
        end
    end

    assign com_inv = ~s_com;
    assign com_ok  = (com_inv != 4'h0) && ((com_inv & (com_inv - 4'd1)) == 4'h0);
    assign com_chg = (s_com != com_prev);
    assign to_hit  = !com_chg && (to_cnt == TO_LAST);

    always_comb begin
        slot_idx = 2'd0;
        slot_bit = 4'b0001;
        case (cur_com)
            4'b1101: begin slot_idx = 2'd1; slot_bit = 4'b0010; end
            4'b1011: begin slot_idx = 2'd2; slot_bit = 4'b0100; end
            4'b0111: begin slot_idx = 2'd3; slot_bit = 4'b1000; end
            default: begin slot_idx = 2'd0; slot_bit = 4'b0001; end
        endcase
    end

    // Active-low segment patterns g..a; a dark digit counts as a valid 0.
    always_comb begin
        dec_digit = 4'd0;
        dec_valid = 1'b1;
        dec_blank = 1'b0;
        case (s_font[6:0])
            7'h40: dec_digit = 4'd0;
            7'h79: dec_digit = 4'd1;
            7'h24: dec_digit = 4'd2;
            7'h30: dec_digit = 4'd3;
            7'h19: dec_digit = 4'd4;
            7'h12: dec_digit = 4'd5;
            7'h02: dec_digit = 4'd6;
            7'h78: dec_digit = 4'd7;
            7'h00: dec_digit = 4'd8;
            7'h10: dec_digit = 4'd9;
            7'h7F: dec_blank = 1'b1;
            default: dec_valid = 1'b0;
        endcase
    end

    // A timeout landing on the sample cycle still discards the older partial frame.
    assign mask_after = (to_hit ? 4'h0 : got_mask) | slot_bit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_COM: if (com_ok) state_d = SETTLE;
            SETTLE: begin
                if (s_com != cur_com)
                    state_d = WAIT_COM;
                else if (s_font == font_prev && settle_cnt == SETTLE_LAST)
                    state_d = SAMPLE;
            end
            SAMPLE:  state_d = (mask_after == 4'hF) ? CONVERT : HOLD;
            HOLD:    if (s_com != cur_com) state_d = WAIT_COM;
            CONVERT: if (conv_cnt == 2'd3) state_d = PUBLISH;
            PUBLISH: state_d = HOLD;
            default: state_d = WAIT_COM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= WAIT_COM;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_com     <= 4'hF;
            settle_cnt  <= '0;
            to_cnt      <= '0;
            conv_cnt    <= 2'd0;
            got_mask    <= 4'h0;
            acc         <= 14'd0;
            slot_d      <= '0;
            slot_dp     <= 4'h0;
            slot_blank  <= 4'h0;
            digit_1     <= 4'd0;
            digit_10    <= 4'd0;
            digit_100   <= 4'd0;
            digit_1000  <= 4'd0;
            value       <= 14'd0;
            dp          <= 4'h0;
            blank       <= 4'h0;
            frame_valid <= 1'b0;
            font_err    <= 1'b0;
            stale       <= 1'b0;
        end else begin
            frame_valid <= 1'b0;

            if (com_chg)             to_cnt <= '0;
            else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;

            if (to_hit) begin
                stale    <= 1'b1;
                got_mask <= 4'h0;
            end

            // The error stays visible through the pulse of the frame that carried it.
            if (frame_valid) font_err <= 1'b0;

            case (state_q)
                WAIT_COM: begin
                    if (com_ok) begin
                        cur_com    <= s_com;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    if (s_font != font_prev) settle_cnt <= '0;
                    else                     settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    slot_d[slot_idx]     <= dec_valid ? dec_digit : 4'd0;
                    slot_dp[slot_idx]    <= ~s_font[7];
                    slot_blank[slot_idx] <= dec_blank;
                    got_mask             <= mask_after;
                    if (!dec_valid) font_err <= 1'b1;
                    acc      <= 14'd0;
                    conv_cnt <= 2'd0;
                end
                CONVERT: begin
                    // Thousands first: ~conv_cnt walks slots 3,2,1,0.
                    acc      <= (acc << 3) + (acc << 1) + 14'(slot_d[~conv_cnt]);
                    conv_cnt <= conv_cnt + 2'd1;
                end
                PUBLISH: begin
                    value       <= acc;
                    digit_1     <= slot_d[0];
                    digit_10    <= slot_d[1];
                    digit_100   <= slot_d[2];
                    digit_1000  <= slot_d[3];
                    dp          <= slot_dp;
                    blank       <= slot_blank;
                    frame_valid <= 1'b1;
                    got_mask    <= 4'h0;
                    stale       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fnd_scan_capture.sv
// Scoreboarded bench: directed scan passes push expected frames, a monitor checks each pulse.
module tb_fnd_scan_capture;
    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 2000;
    localparam int DWELL   = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_font;
    logic [3:0]  digit_1, digit_10, digit_100, digit_1000;
    logic [13:0] value;
    logic [3:0]  dp, blank;
    logic        frame_valid, font_err, stale;

    fnd_scan_capture #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .fnd_com(fnd_com), .fnd_font(fnd_font),
        .digit_1(digit_1), .digit_10(digit_10), .digit_100(digit_100),
        .digit_1000(digit_1000), .value(value), .dp(dp), .blank(blank),
        .frame_valid(frame_valid), .font_err(font_err), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] value;
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        font_err;
        logic        stale;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    task automatic expect_frame(input logic [13:0] v, input logic [15:0] dg, input logic [3:0] dpv,
                                input logic [3:0] blk, input logic fe, input logic st);
        exp_t e;
        e.value = v; e.digits = dg; e.dp = dpv; e.blank = blk; e.font_err = fe; e.stale = st;
        exp_q.push_back(e);
    endtask

    // Every drive starts at posedge+1 and leaves the bench at posedge+1.
    task automatic show(input int pos, input logic [6:0] f, input logic dp_lit, input int dwell);
        fnd_com  = ~(4'b0001 << pos);
        fnd_font = {~dp_lit, f};
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [6:0] f1, input logic [6:0] f10, input logic [6:0] f100,
                         input logic [6:0] f1000, input logic [3:0] dpl);
        show(0, f1, dpl[0], DWELL);
        show(1, f10, dpl[1], DWELL);
        show(2, f100, dpl[2], DWELL);
        show(3, f1000, dpl[3], DWELL);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && frame_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame_valid", {18'd0, value}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("value", {18'd0, value}, {18'd0, e.value});
                chk("digits", {16'd0, digit_1000, digit_100, digit_10, digit_1}, {16'd0, e.digits});
                chk("dp", {28'd0, dp}, {28'd0, e.dp});
                chk("blank", {28'd0, blank}, {28'd0, e.blank});
                chk("font_err", {31'd0, font_err}, {31'd0, e.font_err});
                chk("stale", {31'd0, stale}, {31'd0, e.stale});
            end
        end
    end

    initial begin
        reset    = 1'b0;
        fnd_com  = 4'hF;
        fnd_font = 8'hFF;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_value", {18'd0, value}, 32'd0);
        chk("rst_digits", {16'd0, digit_1000, digit_100, digit_10, digit_1}, 32'd0);
        chk("rst_flags", {25'd0, frame_valid, font_err, stale, dp}, 32'd0);
        chk("rst_blank", {28'd0, blank}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        expect_frame(14'd1234, 16'h1234, 4'h0, 4'h0, 1'b0, 1'b0);
        scan4(seg(4), seg(3), seg(2), seg(1), 4'h0);
        expect_frame(14'd9999, 16'h9999, 4'h0, 4'h0, 1'b0, 1'b0);
        scan4(seg(9), seg(9), seg(9), seg(9), 4'h0);
        expect_frame(14'd0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0);
        scan4(seg(0), seg(0), seg(0), seg(0), 4'h0);
        expect_frame(14'd42, 16'h0042, 4'h0, 4'b1100, 1'b0, 1'b0);
        scan4(seg(2), seg(4), 7'h7F, 7'h7F, 4'h0);

        // Glitch lands where an unrestarted settle count would sample it.
        expect_frame(14'd5678, 16'h5678, 4'h0, 4'h0, 1'b0, 1'b0);
        fnd_com  = 4'b1110;
        fnd_font = {1'b1, seg(8)};
        repeat (15) @(posedge clk);
        #1 fnd_font = {1'b1, 7'h79};
        repeat (3) @(posedge clk);
        #1 fnd_font = {1'b1, seg(8)};
        repeat (DWELL - 18) @(posedge clk);
        #1;
        show(1, seg(7), 1'b0, DWELL);
        show(2, seg(6), 1'b0, DWELL);
        show(3, seg(5), 1'b0, DWELL);

        // Dwell too short to settle: nothing may be published.
        for (int p = 0; p < 4; p++) show(p, seg(p + 1), 1'b0, SETTLE - 1);
        fnd_com = 4'hF;
        repeat (30) @(posedge clk);
        #1;

        expect_frame(14'd2301, 16'h2301, 4'h0, 4'h0, 1'b1, 1'b0);
        scan4(seg(1), 7'h55, seg(3), seg(2), 4'h0);
        expect_frame(14'd8765, 16'h8765, 4'b0100, 4'h0, 1'b0, 1'b0);
        scan4(seg(5), seg(6), seg(7), seg(8), 4'b0100);

        // Partial mask (tens, hundreds, ones) then a stalled bus.
        show(1, seg(9), 1'b0, DWELL);
        show(2, seg(9), 1'b0, DWELL);
        show(0, seg(9), 1'b0, TIMEOUT + 100);
        chk("stale_after_timeout", {31'd0, stale}, 32'd1);
        expect_frame(14'd1357, 16'h1357, 4'h0, 4'h0, 1'b0, 1'b0);
        show(3, seg(1), 1'b0, DWELL);
        show(0, seg(7), 1'b0, DWELL);
        show(1, seg(5), 1'b0, DWELL);
        show(2, seg(3), 1'b0, DWELL);

        // Reset lands inside the conversion of the completing thousands sample.
        show(0, seg(9), 1'b0, DWELL);
        show(1, seg(9), 1'b0, DWELL);
        show(2, seg(9), 1'b0, DWELL);
        fnd_com  = 4'b0111;
        fnd_font = {1'b1, seg(9)};
        repeat (21) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_conv_value", {18'd0, value}, 32'd0);
        chk("rst_conv_digits", {16'd0, digit_1000, digit_100, digit_10, digit_1}, 32'd0);
        chk("rst_conv_flags", {25'd0, frame_valid, font_err, stale, dp}, 32'd0);
        repeat (4) @(posedge clk);
        fnd_com = 4'hF;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        expect_frame(14'd4321, 16'h4321, 4'h0, 4'h0, 1'b0, 1'b0);
        scan4(seg(1), seg(2), seg(3), seg(4), 4'h0);

        repeat (100) @(posedge clk);
        chk("frames_outstanding", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
